lsu_mem_initiator: RTL

Load/store initiator that sits between the core's LSU stage and the single-port data-memory responder. It accepts one byte, half or word access at a time from the core. It converts each access into a word-aligned memory request with a byte write mask and lane-replicated write data. On reads it extracts the addressed lanes from the returned word and sign- or zero-extends them. It also provides misalignment detection and a response timeout, so that a stalled responder can never hang the pipeline.

---
 rtl/lsu_mem_initiator.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns one core byte/half/word access into a word-aligned
// memory request and returns the lane-extracted, extended result or an error.
module lsu_mem_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_valid,
    output logic        o_mem_write_enable,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wmask,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    function automatic logic f_bad_access(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = lane[0];
            2'd2:    bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] f_wmask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] mask;
        case (size)
            2'd0:    mask = 4'b0001 << lane;
            2'd1:    mask = 4'b0011 << {lane[1], 1'b0};
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] data;
        case (size)
            2'd0:    data = {4{d[7:0]}};
            2'd1:    data = {2{d[15:0]}};
            default: data = d;
        endcase
        return data;
    endfunction

    // Lane select then sign/zero extension from bit 7 (byte) or bit 15 (half).
    function automatic logic [31:0] f_load_extend(input logic [1:0] size, input logic uns,
                                                  input logic [1:0] lane, input logic [31:0] word);
        logic [31:0]        shifted;
        logic signed [31:0] ext;
        shifted = word >> {lane, 3'b000};
        case (size)
            2'd0:    ext = uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    ext = uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
        return ext;
    endfunction

    logic [1:0]  r_state;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_write;
    logic        r_unsigned;
    logic [7:0]  r_cnt;
    logic        r_mem_valid;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wmask;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;

    logic [7:0]  w_cnt_next;
    logic        w_expired;
    logic [31:0] w_load_data;

    assign w_cnt_next  = r_cnt + 8'd1;
    assign w_expired   = (w_cnt_next >= LP_TIMEOUT);
    assign w_load_data = r_write ? 32'd0 : f_load_extend(r_size, r_unsigned, r_lane, i_mem_rdata);

    assign o_req_ready        = (r_state == S_IDLE);
    assign o_resp_valid       = r_resp_valid;
    assign o_resp_rdata       = r_resp_rdata;
    assign o_resp_err         = r_resp_err;
    assign o_mem_valid        = r_mem_valid;
    assign o_mem_write_enable = r_mem_valid & r_write;
    assign o_mem_addr         = r_mem_addr;
    assign o_mem_wdata        = r_mem_wdata;
    assign o_mem_wmask        = r_mem_wmask;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_size       <= 2'd0;
            r_lane       <= 2'd0;
            r_write      <= 1'b0;
            r_unsigned   <= 1'b0;
            r_cnt        <= 8'd0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_wmask  <= 4'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_size      <= i_req_size;
                        r_lane      <= i_req_addr[1:0];
                        r_write     <= i_req_write;
                        r_unsigned  <= i_req_unsigned;
                        r_mem_addr  <= {i_req_addr[31:2], 2'b00};
                        r_mem_wdata <= i_req_write ? f_wdata(i_req_size, i_req_wdata) : 32'd0;
                        r_mem_wmask <= i_req_write ? f_wmask(i_req_size, i_req_addr[1:0]) : 4'd0;
                        if (f_bad_access(i_req_size, i_req_addr[1:0])) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'd0;
                        end else begin
                            r_state     <= S_REQ;
                            r_mem_valid <= 1'b1;
                            r_cnt       <= 8'd0;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= w_cnt_next;
                    if (i_mem_ready) begin
                        r_mem_valid <= 1'b0;
                        if (i_mem_rvalid) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                            r_resp_rdata <= w_load_data;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else if (w_expired) begin
                        r_mem_valid  <= 1'b0;
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= 32'd0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_next;
                    if (i_mem_rvalid) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_load_data;
                    end else if (w_expired) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= 32'd0;
                    end
                end
                default: begin
                    // Late memory responses are dropped here; only the core handshake matters.
                    if (i_resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
